// File: rtl/if_fetch_stage.sv
// Instruction fetch stage of the 5-stage RV32 pipeline: PC register, IF/ID buffer,
// stall/flush/halt sequencing and fetch/stall performance counters.
module if_fetch_stage #(
  parameter int unsigned PC_W       = 9,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013,
  parameter logic [31:0] HALT_INSTR = 32'h0000_0073,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic [PC_W-1:0]  branch_target,
  output logic [PC_W-1:0]  imem_addr,
  input  logic [31:0]      imem_rdata,
  output logic [PC_W-1:0]  if_id_pc,
  output logic [31:0]      if_id_instr,
  output logic             if_id_valid,
  output logic [PC_W-1:0]  pc_out,
  output logic             halted,
  output logic [CNT_W-1:0] fetch_count,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [PC_W-1:0]  if_id_pc_q, if_id_pc_d;
  logic [31:0]      if_id_instr_q, if_id_instr_d;
  logic             if_id_valid_q, if_id_valid_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] fetch_count_q, fetch_count_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  logic [PC_W-1:0]  target_aligned;
  logic [PC_W-1:0]  pc_plus4;

  assign target_aligned = {branch_target[PC_W-1:2], 2'b00};
  assign pc_plus4       = pc_q + PC_W'(4);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    // NOTE: every _d defaults to its held value first, so no path through the
    // case below leaves a signal unassigned and no latch is inferred.
    state_d       = state_q;
    pc_d          = pc_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_instr_d = if_id_instr_q;
    if_id_valid_d = if_id_valid_q;
    fetch_count_d = fetch_count_q;
    stall_count_d = stall_count_q;

    unique case (state_q)
      ST_BOOT: begin
        pc_d          = '0;
        if_id_pc_d    = '0;
        if_id_instr_d = NOP_INSTR;
        if_id_valid_d = 1'b0;
        state_d       = ST_RUN;
      end

      ST_RUN: begin
        if (flush) begin
          // Squash the wrong-path fetch; halt detection is skipped on purpose.
          pc_d          = target_aligned;
          if_id_pc_d    = '0;
          if_id_instr_d = NOP_INSTR;
          if_id_valid_d = 1'b0;
        end else if (stall) begin
          stall_count_d = sat_inc(stall_count_q);
        end else begin
          if_id_pc_d    = pc_q;
          if_id_instr_d = imem_rdata;
          if_id_valid_d = 1'b1;
          fetch_count_d = sat_inc(fetch_count_q);
          if (imem_rdata == HALT_INSTR) begin
            state_d = ST_HALT;
          end else begin
            pc_d = pc_plus4;
          end
        end
      end

      ST_HALT: begin
        if_id_pc_d    = '0;
        if_id_instr_d = NOP_INSTR;
        if_id_valid_d = 1'b0;
        if (flush) begin
          // An older branch in EX squashes the ecall and restarts fetch.
          pc_d    = target_aligned;
          state_d = ST_RUN;
        end
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase

    halted_d = (state_d == ST_HALT);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q       <= ST_BOOT;
      pc_q          <= '0;
      if_id_pc_q    <= '0;
      if_id_instr_q <= NOP_INSTR;
      if_id_valid_q <= 1'b0;
      halted_q      <= 1'b0;
      fetch_count_q <= '0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_valid_q <= if_id_valid_d;
      halted_q      <= halted_d;
      fetch_count_q <= fetch_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign imem_addr   = pc_q;
  assign pc_out      = pc_q;
  assign if_id_pc    = if_id_pc_q;
  assign if_id_instr = if_id_instr_q;
  assign if_id_valid = if_id_valid_q;
  assign halted      = halted_q;
  assign fetch_count = fetch_count_q;
  assign stall_count = stall_count_q;

endmodule
